wb_commit: RTL and testbench
============================

# wb_commit

Writeback commit unit sitting between the execute/load result paths and the register file write port (`en`/`rd`/`data`). It accepts results from the ALU and the load unit over valid/ready handshakes and arbitrates them to one register-file write per cycle. It keeps a per-register scoreboard of pending writes and reports read-after-write hazards for the two decode read indices (`rs1`/`rs2`).

## Interface
- `XLEN`, 32, data width
- `NREG`, 32, architectural register count; index width `$clog2(NREG)` (5)
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-low reset
- `issue_valid` in 1: decode issuing an instruction that writes `issue_rd`
- `issue_ready` out 1: issue accepted this cycle
- `issue_rd` in 5: destination of the issuing instruction
- `alu_valid` in 1: ALU result present
- `alu_ready` out 1: ALU result accepted
- `alu_rd` in 5: ALU destination
- `alu_data` in XLEN: ALU result
- `ld_valid` in 1: load result present
- `ld_ready` out 1: load result accepted
- `ld_rd` in 5: load destination
- `ld_data` in XLEN: load result
- `en` out 1: register file write enable (registered)
- `rd` out 5: register file write index (registered)
- `data` out XLEN: register file write data (registered)
- `rs1`, `rs2` in 5: decode read indices
- `op_a_rf`, `op_b_rf` in XLEN: register file read data for `rs1`/`rs2`
- `op_a`, `op_b` out XLEN: operands delivered to execute
- `hz_a`, `hz_b` out 1: operand not yet available, decode must stall
- `busy` out NREG: scoreboard vector, bit r = write to xr pending

## Operation
- Arbitration: fixed priority. A load beats an ALU result.
  - `ld_ready = rst`.
  - `alu_ready = rst & ~ld_valid`.
  - At most one handshake per cycle.
- Commit: an accepted result with destination != 0 is loaded into the output register, giving `en=1`, `rd`, `data` next cycle.
  - An accepted result with destination 0 is consumed and dropped: `en=0`, x0 never written, busy[0] untouched.
  - No accepted result gives `en=0`; `rd`/`data` hold their last values.
- Scoreboard set: an `issue_valid & issue_ready` handshake with `issue_rd != 0` sets busy[issue_rd] at the edge. Issue to x0 is always ready and sets nothing.
- Scoreboard clear: when `en=1`, busy[rd] clears at the following edge.
  - Set and clear of the same index in the same cycle: set wins.
- WAW stall: `issue_ready = rst & (~busy[issue_rd] | (en & rd == issue_rd))`. This allows at most one pending write per register.
- A result whose destination is not busy is still written; the scoreboard is unaffected.
- Hazard: `hz_a = busy[rs1] & (rs1 != 0)`; `hz_b` is the same for `rs2`. Modified under WB_FWD_EN; see Configuration.
- Operands: `op_a = op_a_rf`, `op_b = op_b_rf`, except when forwarding applies.

## Timing
- Reset (`rst=0` at an edge):
  - `en=0`, `rd=0`, `data=0`, `busy=0`.
  - `issue_ready`, `alu_ready`, `ld_ready` are 0 while `rst=0`.
- Reset mid-operation discards any accepted-but-uncommitted result and all pending busy bits.
- Latency: result handshake in cycle N gives `en=1` in cycle N+1, and the register file holds the value from cycle N+2.
- Busy: high from cycle N+1 after the issue handshake in cycle N, through the cycle in which the matching `en=1` is driven; low one cycle later.
- Throughput: one commit per cycle, sustained. The output register never back-pressures.
- Starvation: continuous `ld_valid` starves the ALU. Accepted; the load unit never issues back-to-back for more than 4 cycles.
- `hz_*`, `op_*` and all `*_ready` outputs are combinational from inputs and registered state. Every other output is registered.

## Configuration
- Macro: `WB_FWD_EN`.
- Defined: bypass from the output register.
  - If `en & rd == rs1 & rs1 != 0`, then `op_a = data` and `hz_a` is forced 0. Same for `rs2`/`op_b`/`hz_b`.
  - This removes the one-cycle read-during-write bubble of the register file.
- Undefined:
  - `op_a`/`op_b` pass straight through from `op_*_rf`.
  - `hz_*` stays high through the commit cycle and drops one cycle later, when the register file holds the value.

## Structure
- Shared package `wb_pkg`:
  - `XLEN`, `NREG`, `REG_AW` constants.
  - `reg_idx_t` typedef.
  - `wb_req_t` struct {valid, rd, data}.
- Sub-module `wb_scoreboard`: NREG-bit busy vector with set/clear ports (set priority), x0 masking, and the two hazard lookups.
- Arbitration, the output register and forwarding live in `wb_commit`.

## Test plan
- Reset: hold `rst=0` 2 cycles with `alu_valid=1` → `en=0`, `busy=0`, all readies 0. After release, `alu_ready=1`.
- Issue then ALU result:
  - Stimulus: issue rd=1, then alu rd=1 data=DEADBEEF.
  - Required: busy[1]=1 and `hz_a=1` for rs1=1. One cycle after acceptance, `en=1 rd=1 data=DEADBEEF`; busy[1]=0 the cycle after.
- x0 handling:
  - Issue rd=0 → busy unchanged.
  - ALU rd=0 data=12345678 accepted → `en` stays 0.
  - rs1=0 → `hz_a=0`.
- Collision: `ld_valid` and `alu_valid` both high (ld rd=2 CAFEBABE, alu rd=3 55555555).
  - Cycle 0: `ld_ready=1`, `alu_ready=0`.
  - Commits in order: rd=2, then rd=3.
- WAW stall: with rd=4 busy, issue rd=4 → `issue_ready=0` until the cycle with `en=1 rd=4`, where `issue_ready=1`. busy[4] stays 1 after that edge.
- Forwarding (`WB_FWD_EN`): rs1=4 during the commit cycle of rd=4 data=AAAAAAAA → `op_a=AAAAAAAA`, `hz_a=0`. Without the macro → `hz_a=1` that cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback commit unit.
// Optional feature macro: WB_FWD_EN (bypass from the commit output register).
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   word_t;

  // One candidate register-file write coming from a result source.
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    word_t    data;
  } wb_req_t;

  // x0 is hardwired to zero, so it is never tracked and never written.
  function automatic logic is_x0(reg_idx_t idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/wb_commit_if.sv
// Bus bundle between decode/execute/load and the writeback commit unit.
// The master side is the surrounding pipeline, the slave side is wb_commit.
interface wb_commit_if;
  import wb_pkg::*;

  logic              issue_valid;
  logic              issue_ready;
  reg_idx_t          issue_rd;

  logic              alu_valid;
  logic              alu_ready;
  reg_idx_t          alu_rd;
  word_t             alu_data;

  logic              ld_valid;
  logic              ld_ready;
  reg_idx_t          ld_rd;
  word_t             ld_data;

  logic              en;
  reg_idx_t          rd;
  word_t             data;

  reg_idx_t          rs1;
  reg_idx_t          rs2;
  word_t             op_a_rf;
  word_t             op_b_rf;
  word_t             op_a;
  word_t             op_b;
  logic              hz_a;
  logic              hz_b;

  logic [NREG-1:0]   busy;

  modport master (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output rs1, rs2, op_a_rf, op_b_rf,
    input  issue_ready, alu_ready, ld_ready,
    input  en, rd, data,
    input  op_a, op_b, hz_a, hz_b, busy
  );

  modport slave (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  rs1, rs2, op_a_rf, op_b_rf,
    output issue_ready, alu_ready, ld_ready,
    output en, rd, data,
    output op_a, op_b, hz_a, hz_b, busy
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard with set-over-clear priority,
// x0 masking and the two decode hazard lookups.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  reg_idx_t        set_idx,
  input  logic            clr_en,
  input  reg_idx_t        clr_idx,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  output logic [NREG-1:0] busy,
  output logic            hz_a,
  output logic            hz_b
);

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Decode set/clear requests into one-hot masks, never touching x0.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && !is_x0(set_idx)) set_mask[set_idx] = 1'b1;
    if (clr_en && !is_x0(clr_idx)) clr_mask[clr_idx] = 1'b1;
  end

  // Busy vector update; OR-ing the set after the clear makes set win on a tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  // A read of x0 never has to wait.
  always_comb begin
    hz_a = busy[rs1] & ~is_x0(rs1);
    hz_b = busy[rs2] & ~is_x0(rs2);
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit unit: arbitrates load/ALU results onto the register
// file write port, tracks pending writes and reports decode hazards.
// Optional feature macro: WB_FWD_EN (forward the output register to op_a/op_b).
module wb_commit
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  wb_commit_if.slave  bus
);

  wb_req_t         win_req;
  logic            ld_fire;
  logic            alu_fire;
  logic            issue_ok;

  logic            en_q;
  reg_idx_t        rd_q;
  word_t           data_q;

  logic [NREG-1:0] busy_vec;
  logic            sb_hz_a;
  logic            sb_hz_b;

  // Fixed priority: a load always wins, the ALU only goes when no load waits.
  always_comb begin
    bus.ld_ready  = rst;
    bus.alu_ready = rst & ~bus.ld_valid;
    ld_fire       = bus.ld_valid & rst;
    alu_fire      = bus.alu_valid & rst & ~bus.ld_valid;
  end

  // Pick the single accepted result for this cycle, if any.
  always_comb begin
    win_req = '0;
    if (ld_fire) begin
      win_req.valid = 1'b1;
      win_req.rd    = bus.ld_rd;
      win_req.data  = bus.ld_data;
    end else if (alu_fire) begin
      win_req.valid = 1'b1;
      win_req.rd    = bus.alu_rd;
      win_req.data  = bus.alu_data;
    end
  end

  // Output register; results aimed at x0 are swallowed and rd/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else if (win_req.valid && !is_x0(win_req.rd)) begin
      en_q   <= 1'b1;
      rd_q   <= win_req.rd;
      data_q <= win_req.data;
    end else begin
      en_q   <= 1'b0;
    end
  end

  // One pending write per register: re-issue waits until the old write is on the port.
  always_comb begin
    issue_ok        = ~busy_vec[bus.issue_rd] | (en_q & (rd_q == bus.issue_rd));
    bus.issue_ready = rst & issue_ok;
  end

  wb_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (bus.issue_valid & rst & issue_ok),
    .set_idx (bus.issue_rd),
    .clr_en  (en_q),
    .clr_idx (rd_q),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .busy    (busy_vec),
    .hz_a    (sb_hz_a),
    .hz_b    (sb_hz_b)
  );

  // Registered outputs straight from the commit register and scoreboard.
  always_comb begin
    bus.en   = en_q;
    bus.rd   = rd_q;
    bus.data = data_q;
    bus.busy = busy_vec;
  end

`ifdef WB_FWD_EN
  logic fwd_a;
  logic fwd_b;

  // Bypass the value sitting in the output register so decode need not wait for the RF.
  always_comb begin
    fwd_a    = en_q & (rd_q == bus.rs1) & ~is_x0(bus.rs1);
    fwd_b    = en_q & (rd_q == bus.rs2) & ~is_x0(bus.rs2);
    bus.op_a = fwd_a ? data_q : bus.op_a_rf;
    bus.op_b = fwd_b ? data_q : bus.op_b_rf;
    bus.hz_a = sb_hz_a & ~fwd_a;
    bus.hz_b = sb_hz_b & ~fwd_b;
  end
`else
  // Without bypass, operands come from the RF and hazards last through the commit cycle.
  always_comb begin
    bus.op_a = bus.op_a_rf;
    bus.op_b = bus.op_b_rf;
    bus.hz_a = sb_hz_a;
    bus.hz_b = sb_hz_b;
  end
`endif

  // Only one result source may hand off per cycle.
  a_one_handshake: assert property (@(posedge clk) disable iff (!rst) !(ld_fire && alu_fire));

  // x0 must never appear pending.
  a_x0_idle: assert property (@(posedge clk) disable iff (!rst) !busy_vec[0]);

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: a directed vector table plus
// hand-written reset-mid-operation and sustained-throughput sequences.
module tb_wb_commit;
  import wb_pkg::*;

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam bit HZC = FWD ? 1'b0 : 1'b1;

  localparam word_t RFA = 32'h0A0A_0A0A;
  localparam word_t RFB = 32'h0B0B_0B0B;
  localparam word_t DB  = 32'hDEAD_BEEF;
  localparam word_t CB  = 32'hCAFE_BABE;
  localparam word_t FV  = 32'h5555_5555;
  localparam word_t AV  = 32'hAAAA_AAAA;

  typedef struct {
    bit        rst;
    bit        iv;
    reg_idx_t  ird;
    bit        av;
    reg_idx_t  ard;
    word_t     adata;
    bit        lv;
    reg_idx_t  lrd;
    word_t     ldata;
    reg_idx_t  rs1;
    reg_idx_t  rs2;
    bit        e_en;
    reg_idx_t  e_rd;
    word_t     e_data;
    logic [31:0] e_busy;
    bit        e_irdy;
    bit        e_ardy;
    bit        e_lrdy;
    bit        e_hza;
    bit        e_hzb;
    word_t     e_opa;
    word_t     e_opb;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  vec_t vecs[$];

  wb_commit_if bus ();

  wb_commit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst             = v.rst;
    bus.issue_valid = v.iv;
    bus.issue_rd    = v.ird;
    bus.alu_valid   = v.av;
    bus.alu_rd      = v.ard;
    bus.alu_data    = v.adata;
    bus.ld_valid    = v.lv;
    bus.ld_rd       = v.lrd;
    bus.ld_data     = v.ldata;
    bus.rs1         = v.rs1;
    bus.rs2         = v.rs2;
    bus.op_a_rf     = RFA;
    bus.op_b_rf     = RFB;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    n_vec++;
    checkField({p, ".en"},          32'(bus.en),          32'(v.e_en));
    checkField({p, ".rd"},          32'(bus.rd),          32'(v.e_rd));
    checkField({p, ".data"},        bus.data,             v.e_data);
    checkField({p, ".busy"},        bus.busy,             v.e_busy);
    checkField({p, ".issue_ready"}, 32'(bus.issue_ready), 32'(v.e_irdy));
    checkField({p, ".alu_ready"},   32'(bus.alu_ready),   32'(v.e_ardy));
    checkField({p, ".ld_ready"},    32'(bus.ld_ready),    32'(v.e_lrdy));
    checkField({p, ".hz_a"},        32'(bus.hz_a),        32'(v.e_hza));
    checkField({p, ".hz_b"},        32'(bus.hz_b),        32'(v.e_hzb));
    checkField({p, ".op_a"},        bus.op_a,             v.e_opa);
    checkField({p, ".op_b"},        bus.op_b,             v.e_opb);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    // rst, iv,ird, av,ard,adata, lv,lrd,ldata, rs1,rs2 | en,rd,data,busy, irdy,ardy,lrdy, hza,hzb, opa,opb
    // reset held with a pending ALU result
    vecs.push_back(vec_t'{0, 0,0, 1,5,32'h77, 0,0,0, 0,0, 0,0,0,32'h0, 0,0,0, 0,0, RFA,RFB});
    vecs.push_back(vec_t'{0, 0,0, 1,5,32'h77, 0,0,0, 0,0, 0,0,0,32'h0, 0,0,0, 0,0, RFA,RFB});
    // issue x1, then ALU result for x1
    vecs.push_back(vec_t'{1, 1,1, 0,0,0, 0,0,0, 1,0, 0,0,0,32'h0, 1,1,1, 0,0, RFA,RFB});
    vecs.push_back(vec_t'{1, 0,0, 1,1,DB, 0,0,0, 1,0, 0,0,0,32'h2, 1,1,1, 1,0, RFA,RFB});
    vecs.push_back(vec_t'{1, 0,0, 0,0,0, 0,0,0, 1,0, 1,1,DB,32'h2, 1,1,1, HZC,0, FWD ? DB : RFA,RFB});
    vecs.push_back(vec_t'{1, 0,0, 0,0,0, 0,0,0, 1,0, 0,1,DB,32'h0, 1,1,1, 0,0, RFA,RFB});
    // x0: issue, ALU write, and read
    vecs.push_back(vec_t'{1, 1,0, 0,0,0, 0,0,0, 0,0, 0,1,DB,32'h0, 1,1,1, 0,0, RFA,RFB});
    vecs.push_back(vec_t'{1, 0,0, 1,0,32'h1234_5678, 0,0,0, 0,0, 0,1,DB,32'h0, 1,1,1, 0,0, RFA,RFB});
    vecs.push_back(vec_t'{1, 0,0, 0,0,0, 0,0,0, 0,0, 0,1,DB,32'h0, 1,1,1, 0,0, RFA,RFB});
    // load/ALU collision on x2/x3
    vecs.push_back(vec_t'{1, 1,2, 0,0,0, 0,0,0, 0,0, 0,1,DB,32'h0, 1,1,1, 0,0, RFA,RFB});
    vecs.push_back(vec_t'{1, 1,3, 0,0,0, 0,0,0, 0,0, 0,1,DB,32'h4, 1,1,1, 0,0, RFA,RFB});
    vecs.push_back(vec_t'{1, 0,0, 1,3,FV, 1,2,CB, 2,3, 0,1,DB,32'hC, 1,0,1, 1,1, RFA,RFB});
    vecs.push_back(vec_t'{1, 0,0, 1,3,FV, 0,0,0, 2,3, 1,2,CB,32'hC, 1,1,1, HZC,1, FWD ? CB : RFA,RFB});
    vecs.push_back(vec_t'{1, 0,0, 0,0,0, 0,0,0, 2,3, 1,3,FV,32'h8, 1,1,1, 0,HZC, RFA,FWD ? FV : RFB});
    vecs.push_back(vec_t'{1, 0,0, 0,0,0, 0,0,0, 2,3, 0,3,FV,32'h0, 1,1,1, 0,0, RFA,RFB});
    // WAW stall on x4 and same-cycle set/clear
    vecs.push_back(vec_t'{1, 1,4, 0,0,0, 0,0,0, 0,0, 0,3,FV,32'h0, 1,1,1, 0,0, RFA,RFB});
    vecs.push_back(vec_t'{1, 1,4, 0,0,0, 0,0,0, 0,0, 0,3,FV,32'h10, 0,1,1, 0,0, RFA,RFB});
    vecs.push_back(vec_t'{1, 1,4, 1,4,AV, 0,0,0, 0,0, 0,3,FV,32'h10, 0,1,1, 0,0, RFA,RFB});
    vecs.push_back(vec_t'{1, 1,4, 0,0,0, 0,0,0, 4,0, 1,4,AV,32'h10, 1,1,1, HZC,0, FWD ? AV : RFA,RFB});
    vecs.push_back(vec_t'{1, 0,0, 0,0,0, 0,0,0, 4,0, 0,4,AV,32'h10, 1,1,1, 1,0, RFA,RFB});

    // Initial reset edge so the table starts from a known state.
    applyStimulus(vecs[0]);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
      tick();
    end

    // Reset while a result sits in the output register with x4 pending.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd4;
    bus.alu_data  = 32'h1357_9BDF;
    bus.rs1       = 5'd0;
    #1;
    n_vec++;
    checkField("midrst.accept", 32'(bus.alu_ready), 32'd1);
    tick();
    rst           = 1'b0;
    bus.alu_valid = 1'b0;
    #1;
    n_vec++;
    checkField("midrst.en_before", 32'(bus.en), 32'd1);
    checkField("midrst.data_before", bus.data, 32'h1357_9BDF);
    checkField("midrst.ready_in_rst", {29'd0, bus.issue_ready, bus.alu_ready, bus.ld_ready}, 32'd0);
    tick();
    #1;
    n_vec++;
    checkField("midrst.en", 32'(bus.en), 32'd0);
    checkField("midrst.rd", 32'(bus.rd), 32'd0);
    checkField("midrst.data", bus.data, 32'd0);
    checkField("midrst.busy", bus.busy, 32'd0);
    rst = 1'b1;

    // Sustained throughput: three issues, then three back-to-back ALU commits.
    for (int k = 0; k < 3; k++) begin
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'(5 + k);
      tick();
    end
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    #1;
    n_vec++;
    checkField("thru.busy_set", bus.busy, 32'hE0);
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(5 + k);
      bus.alu_data  = 32'h1000_0000 + 32'(k);
      #1;
      n_vec++;
      checkField($sformatf("thru.ready%0d", k), 32'(bus.alu_ready), 32'd1);
      if (k > 0) begin
        checkField($sformatf("thru.en%0d", k), 32'(bus.en), 32'd1);
        checkField($sformatf("thru.rd%0d", k), 32'(bus.rd), 32'(5 + k - 1));
        checkField($sformatf("thru.data%0d", k), bus.data, 32'h1000_0000 + 32'(k - 1));
      end
      tick();
    end
    bus.alu_valid = 1'b0;
    #1;
    n_vec++;
    checkField("thru.en_last", 32'(bus.en), 32'd1);
    checkField("thru.rd_last", 32'(bus.rd), 32'd7);
    checkField("thru.data_last", bus.data, 32'h1000_0002);
    begin
      int cyc;
      cyc = 0;
      while (bus.busy !== 32'd0 && cyc < 4) begin
        tick();
        #1;
        cyc++;
      end
      n_vec++;
      checkField("thru.busy_drain", bus.busy, 32'd0);
      checkField("thru.drain_cycles", 32'(cyc), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
